// File: rtl/data_mem_cache_sa_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the set-associative data cache and its byte lane.
package data_mem_cache_sa_pkg;

    typedef enum logic [1:0] {
        LOOKUP    = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        DONE      = 2'd3
    } cache_state_t;

    localparam int ADDR_W = 14;

    // sign_mask bit positions
    localparam int SM_SIGN = 3;
    localparam int SM_WORD = 2;
    localparam int SM_HALF = 1;

    // Byte-offset bits covering one line
    function automatic int calc_off(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    // Set-index bits
    function automatic int calc_idx(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over from the 14-bit byte address
    function automatic int calc_tag(input int line_words, input int sets);
        return ADDR_W - calc_off(line_words) - calc_idx(sets);
    endfunction

endpackage

// File: rtl/data_mem_byte_lane.sv
`timescale 1ns/1ps
// Store-merge and load-extract/extend of one 32-bit word.
module data_mem_byte_lane
    import data_mem_cache_sa_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  offset,
    input  logic [3:0]  sign_mask,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_mask;

    assign unused_mask = sign_mask[0];

    // Merge word, half or byte store data into the addressed word
    always_comb begin
        merged_word = old_word;
        if (sign_mask[SM_WORD]) begin
            merged_word = store_data;
        end else if (sign_mask[SM_HALF]) begin
            if (offset[1]) merged_word[31:16] = store_data[15:0];
            else           merged_word[15:0]  = store_data[15:0];
        end else begin
            case (offset)
                2'd0:    merged_word[7:0]   = store_data[7:0];
                2'd1:    merged_word[15:8]  = store_data[7:0];
                2'd2:    merged_word[23:16] = store_data[7:0];
                default: merged_word[31:24] = store_data[7:0];
            endcase
        end
    end

    // Extract the addressed byte/half/word and zero- or sign-extend it
    always_comb begin
        half_sel = offset[1] ? old_word[31:16] : old_word[15:0];
        byte_sel = old_word[7:0];
        case (offset)
            2'd0:    byte_sel = old_word[7:0];
            2'd1:    byte_sel = old_word[15:8];
            2'd2:    byte_sel = old_word[23:16];
            default: byte_sel = old_word[31:24];
        endcase
        if (sign_mask[SM_WORD])
            load_word = old_word;
        else if (sign_mask[SM_HALF])
            load_word = sign_mask[SM_SIGN] ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        else
            load_word = sign_mask[SM_SIGN] ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
    end

endmodule

// File: rtl/data_mem_cache_sa.sv
`timescale 1ns/1ps
// Set-associative write-back data cache with LRU replacement and a
// req/ack line-wide backing-memory port.
module data_mem_cache_sa
    import data_mem_cache_sa_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [13:0]                        addr,
    input  logic [31:0]                        write_data,
    input  logic                               memwrite,
    input  logic                               memread,
    input  logic [3:0]                         sign_mask,
    output logic [31:0]                        read_data,
    output logic                               clk_stall,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [13-calc_off(LINE_WORDS):0]   mem_addr,
    output logic [32*LINE_WORDS-1:0]           mem_wdata,
    input  logic [32*LINE_WORDS-1:0]           mem_rdata,
    input  logic                               mem_ack,
    output logic [15:0]                        hit_count,
    output logic [15:0]                        miss_count
);

    localparam int OFF    = calc_off(LINE_WORDS);
    localparam int IDX    = calc_idx(SETS);
    localparam int TAG    = calc_tag(LINE_WORDS, SETS);
    localparam int IDX_W  = (IDX > 0) ? IDX : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int MA_W   = 14 - OFF;

    cache_state_t      state_q, state_d;

    logic [TAG-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];
    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];

    logic [13:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_mask;
    logic              lat_store;
    logic [WAY_W-1:0]  victim_q;

    logic              in_lookup, access, hit, hit_evt, miss_evt, store_now;
    logic [13:0]       acc_addr;
    logic [IDX_W-1:0]  set_idx;
    logic [TAG-1:0]    acc_tag;
    int                wsel;
    logic [WAY_W-1:0]  hit_way, victim, way_sel, old_age;
    logic [WAY_W-1:0]  new_age [WAYS];
    logic [LINE_W-1:0] line_sel, merged_line;
    logic [31:0]       old_word, lane_wdata, merged_word, load_word;
    logic [3:0]        lane_mask;

    assign in_lookup = (state_q == LOOKUP);
    assign access    = memread | memwrite;
    // During a miss the latched request drives the whole datapath
    assign acc_addr  = in_lookup ? addr : lat_addr;
    assign set_idx   = IDX_W'((acc_addr >> OFF) & 14'(SETS - 1));
    assign acc_tag   = TAG'(acc_addr >> (OFF + IDX));
    assign wsel      = int'((acc_addr >> 2) & 14'(LINE_WORDS - 1));

    // Tag compare across the indexed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == acc_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the least recently used
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (age_q[set_idx][w] == '0) victim = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[set_idx][w]) victim = WAY_W'(w);
    end

    assign hit_evt   = in_lookup && access && hit;
    assign miss_evt  = in_lookup && access && !hit;
    assign way_sel   = in_lookup ? hit_way : victim_q;
    assign store_now = in_lookup ? memwrite : lat_store;
    assign line_sel  = (state_q == REFILL) ? mem_rdata : line_q[set_idx][way_sel];
    assign lane_wdata = in_lookup ? write_data : lat_wdata;
    assign lane_mask  = in_lookup ? sign_mask : lat_mask;

    // Pick the addressed word and splice the merged store word back in
    always_comb begin
        old_word    = line_sel[31:0];
        merged_line = line_sel;
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (k == wsel) begin
                old_word = line_sel[k*32 +: 32];
                if (store_now) merged_line[k*32 +: 32] = merged_word;
            end
        end
    end

    data_mem_byte_lane u_lane (
        .old_word    (old_word),
        .store_data  (lane_wdata),
        .offset      (acc_addr[1:0]),
        .sign_mask   (lane_mask),
        .merged_word (merged_word),
        .load_word   (load_word)
    );

    // LRU ages after touching way_sel: it becomes newest, younger ways shift down
    always_comb begin
        old_age = age_q[set_idx][way_sel];
        for (int w = 0; w < WAYS; w++) begin
            new_age[w] = age_q[set_idx][w];
            if (WAY_W'(w) == way_sel)
                new_age[w] = WAY_W'(WAYS - 1);
            else if (age_q[set_idx][w] > old_age)
                new_age[w] = age_q[set_idx][w] - 1'b1;
        end
    end

    // Next-state logic and backing-memory handshake outputs
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = MA_W'(lat_addr >> OFF);
        mem_wdata = line_q[set_idx][victim_q];
        case (state_q)
            LOOKUP: begin
                if (miss_evt)
                    state_d = (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = (MA_W'(tag_q[set_idx][victim_q]) << IDX) | MA_W'(set_idx);
                if (mem_ack) state_d = REFILL;
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = DONE;
            end
            DONE:    state_d = LOOKUP;
            default: state_d = LOOKUP;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOOKUP;
        else        state_q <= state_d;
    end

    // Core-facing result, stall, counters and chosen victim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            clk_stall  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            victim_q   <= '0;
        end else begin
            if (hit_evt) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                if (!memwrite) read_data <= load_word;
            end
            if (miss_evt) begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                clk_stall <= 1'b1;
                victim_q  <= victim;
            end
            if (state_q == DONE) begin
                clk_stall <= 1'b0;
                if (!lat_store) read_data <= load_word;
            end
        end
    end

    // Valid, dirty and LRU bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (hit_evt || (state_q == DONE))
                for (int w = 0; w < WAYS; w++) age_q[set_idx][w] <= new_age[w];
            if (hit_evt && memwrite)
                dirty_q[set_idx][hit_way] <= 1'b1;
            if ((state_q == REFILL) && mem_ack) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= lat_store;
            end
        end
    end

    // Line data, tags and the latched miss request
    always_ff @(posedge clk) begin
        if (miss_evt) begin
            lat_addr  <= addr;
            lat_wdata <= write_data;
            lat_mask  <= sign_mask;
            lat_store <= memwrite;
        end
        if (hit_evt && memwrite)
            line_q[set_idx][hit_way] <= merged_line;
        if ((state_q == REFILL) && mem_ack) begin
            line_q[set_idx][victim_q] <= merged_line;
            tag_q[set_idx][victim_q]  <= acc_tag;
        end
    end

endmodule
